// File: rtl/layer1_weight_storage.sv
// layer1_weight_storage
// Flip-flop register file holding one packed layer-1 weight word per input
// node. Synchronous write, combinational read, synchronous clear.
// Weight k of a word lives at bits [k*LAYER_1_BIT_WIDTH +: LAYER_1_BIT_WIDTH];
// the bits are stored verbatim and never interpreted here.
module layer1_weight_storage #(
  parameter int RELU_NODES        = 16,
  parameter int LAYER_1_BIT_WIDTH = 16,
  parameter int INPUT_NODES       = 784
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      writeEnable,
  input  logic [9:0]                                NodeSelect,
  input  logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0]   writeIn,
  output logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0]   readOut
);

  localparam int         W     = RELU_NODES * LAYER_1_BIT_WIDTH;
  // 11 bits so that a depth of exactly 1024 still fits in the compare
  localparam logic [10:0] DEPTH = 11'(INPUT_NODES);

  logic [W-1:0] mem [INPUT_NODES];
  logic         in_range;

  // Indices at or beyond the stored depth neither write nor read
  assign in_range = ({1'b0, NodeSelect} < DEPTH);

  // Clear every word on reset (dropping any simultaneous write), else store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < INPUT_NODES; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEnable && in_range) begin
      mem[NodeSelect] <= writeIn;
    end
  end

  // Combinational read of the selected word, zero when out of range
  always_comb begin
    readOut = '0;
    if (in_range) begin
      readOut = mem[NodeSelect];
    end
  end

endmodule

// File: tb/tb_layer1_weight_storage.sv
// Directed self-checking bench for layer1_weight_storage (default parameters).
module tb_layer1_weight_storage;

  localparam int W  = 256;
  localparam int BW = 16;

  logic         clk;
  logic         reset;
  logic         writeEnable;
  logic [9:0]   NodeSelect;
  logic [W-1:0] writeIn;
  logic [W-1:0] readOut;

  int checks = 0;
  int errors = 0;

  layer1_weight_storage dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .NodeSelect  (NodeSelect),
    .writeIn     (writeIn),
    .readOut     (readOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_node(input int node, input string tag, input logic [W-1:0] exp);
    NodeSelect = 10'(node);
    #1;
    check(tag, readOut, exp);
  endtask

  task automatic write_node(input int node, input logic [W-1:0] val);
    NodeSelect  = 10'(node);
    writeIn     = val;
    writeEnable = 1'b1;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
  endtask

  logic [W-1:0] packed_word;

  initial begin
    reset       = 1'b1;
    writeEnable = 1'b0;
    NodeSelect  = '0;
    writeIn     = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    read_node(0,   "rst_n0",   '0);
    read_node(1,   "rst_n1",   '0);
    read_node(783, "rst_n783", '0);

    // Back-to-back writes to node 0; last value held
    NodeSelect  = 10'd0;
    writeIn     = W'(38);
    writeEnable = 1'b1;
    @(posedge clk); #1;
    check("wr38", readOut, W'(38));
    writeIn = W'(602);
    @(posedge clk); #1;
    check("wr602", readOut, W'(602));
    writeEnable = 1'b0;
    writeIn     = W'(52);
    @(posedge clk); #1;
    check("hold602", readOut, W'(602));

    write_node(1, W'(52));
    check("wr_n1", readOut, W'(52));
    read_node(0, "rd_n0", W'(602));
    read_node(1, "rd_n1", W'(52));
    read_node(2, "rd_n2", '0);

    // No same-cycle bypass: before the edge the old contents are shown
    NodeSelect  = 10'd2;
    writeIn     = W'(5);
    writeEnable = 1'b1;
    #1;
    check("no_bypass", readOut, '0);
    @(posedge clk); #1;
    writeEnable = 1'b0;
    check("wr_n2", readOut, W'(5));

    // Packed word with distinct fields at the last node
    for (int k = 0; k < 16; k++) packed_word[k*BW +: BW] = 16'(k + 1);
    write_node(783, packed_word);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (readOut[k*BW +: BW] !== 16'(k + 1)) begin
        errors++;
        $display("FAIL field%0d got %h expected %h", k, readOut[k*BW +: BW], 16'(k + 1));
      end
    end
    check("n783_word", readOut, packed_word);
    read_node(782, "n782_zero", '0);

    // Out-of-range write ignored, read zero
    NodeSelect  = 10'd800;
    writeIn     = W'(16'hFFFF);
    writeEnable = 1'b1;
    #1;
    check("oor_rd_pre", readOut, '0);
    @(posedge clk); #1;
    writeEnable = 1'b0;
    check("oor_rd", readOut, '0);
    read_node(784, "oor_784", '0);
    read_node(0, "oor_keep0", W'(602));
    read_node(1, "oor_keep1", W'(52));
    read_node(783, "oor_keep783", packed_word);

    // Reset wins over a simultaneous write
    reset       = 1'b1;
    writeEnable = 1'b1;
    NodeSelect  = 10'd0;
    writeIn     = W'(77);
    @(posedge clk); #1;
    reset       = 1'b0;
    writeEnable = 1'b0;
    read_node(0,   "rstwr_n0",   '0);
    read_node(1,   "rstwr_n1",   '0);
    read_node(2,   "rstwr_n2",   '0);
    read_node(783, "rstwr_n783", '0);

    // Writes resume after reset
    write_node(5, W'(9));
    check("resume_n5", readOut, W'(9));
    read_node(0, "resume_n0", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
